gamepad_poller: RTL

Parametrised multi-port serial gamepad poller for NES (8-bit) and SNES (16-bit) controllers. One shared latch line and one shared clock line drive up to NUM_PADS controllers; each controller returns its own serial data line. The block polls all pads at a programmable rate and presents debounced-by-frame, active-high button words with a one-cycle valid strobe to the core input logic.

---
 rtl/gamepad_poller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gamepad_poller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gamepad_poller - shared latch/clock NES/SNES poller; optional GAMEPAD_PRESENT_DETECT_EN. Rev 1.0
// ----------------------------------------------------------------------------
module gamepad_poller #(
  parameter int NUM_PADS     = 2,
  parameter int NUM_BITS     = 8,
  parameter int HALF_PERIOD  = 162,
  parameter int LATCH_CYCLES = 324,
  parameter int POLL_CYCLES  = 225000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic [NUM_PADS-1:0]          i_serial_data,
  output logic                         o_data_latch,
  output logic                         o_data_clock,
  output logic [NUM_PADS*NUM_BITS-1:0] o_buttons,
  output logic                         o_valid,
  output logic [NUM_PADS-1:0]          o_present
);

`ifdef GAMEPAD_PRESENT_DETECT_EN
  localparam int NB = NUM_BITS + 1;
`else
  localparam int NB = NUM_BITS;
`endif
  localparam int TMR_W   = $clog2(POLL_CYCLES + 1);
  localparam int CNT_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NB);

  localparam logic [TMR_W-1:0] POLL_LOAD  = TMR_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NB - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LATCH  = 2'd1;
  localparam logic [1:0] CLK_LO = 2'd2;
  localparam logic [1:0] CLK_HI = 2'd3;

  logic [1:0]                   state;
  logic [TMR_W-1:0]             timer;
  logic [CNT_W-1:0]             cnt;
  logic [IDX_W-1:0]             idx;
  logic [NUM_PADS-1:0]          sync1;
  logic [NUM_PADS-1:0]          sync2;
  logic [NB-1:0]                shreg [NUM_PADS];
  logic [NUM_PADS*NUM_BITS-1:0] commit_buttons;
  logic [NUM_PADS-1:0]          commit_present;
  logic                         start;

  assign start = (state == IDLE) && i_enable && (timer == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= i_serial_data;
      sync2 <= sync1;
    end
  end

  // Free-running frame-rate timer; it keeps counting in IDLE so a late enable starts at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      timer <= '0;
    else if (start)
      timer <= POLL_LOAD;
    else if (timer != '0)
      timer <= timer - TMR_W'(1);
  end

  // Shift registers hold active-high bits; the presence bit is stored inverted too (1 = pad drove 0).
  always_comb begin
    commit_buttons = '0;
    commit_present = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
`ifdef GAMEPAD_PRESENT_DETECT_EN
      commit_present[p] = shreg[p][NUM_BITS];
      commit_buttons[p*NUM_BITS +: NUM_BITS] =
        shreg[p][NUM_BITS] ? shreg[p][NUM_BITS-1:0] : '0;
`else
      commit_buttons[p*NUM_BITS +: NUM_BITS] = shreg[p][NUM_BITS-1:0];
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      o_data_latch <= 1'b0;
      o_data_clock <= 1'b0;
      o_valid      <= 1'b0;
      o_buttons    <= '0;
      o_present    <= '1;
      for (int p = 0; p < NUM_PADS; p++) shreg[p] <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LATCH;
            o_data_latch <= 1'b1;
            cnt          <= LATCH_LOAD;
          end
        end
        LATCH: begin
          if (cnt == '0) begin
            state        <= CLK_LO;
            o_data_latch <= 1'b0;
            cnt          <= HALF_LOAD;
            idx          <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CLK_LO: begin
          if (cnt == '0) begin
            state        <= CLK_HI;
            o_data_clock <= 1'b1;
            cnt          <= HALF_LOAD;
            for (int p = 0; p < NUM_PADS; p++) shreg[p][idx] <= ~sync2[p];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CLK_HI: begin
          if (cnt == '0) begin
            o_data_clock <= 1'b0;
            if (idx == IDX_LAST) begin
              state     <= IDLE;
              o_valid   <= 1'b1;
              o_buttons <= commit_buttons;
              o_present <= commit_present;
            end else begin
              state <= CLK_LO;
              idx   <= idx + IDX_W'(1);
              cnt   <= HALF_LOAD;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
